// File: rtl/cereal_rx_if.sv
// cereal_rx_if: receiver-side signal bundle for the cereal serial link.
// The master modport drives the line and consumer controls; the slave modport
// belongs to the receiver. DEPTH must match the receiver FIFO depth.
interface cereal_rx_if #(
   parameter int DEPTH = 4
);
   logic                     rx;
   logic                     rd_en;
   logic                     clr;
   logic [7:0]               data;
   logic                     valid;
   logic [$clog2(DEPTH):0]   count;
   logic                     busy;
   logic                     frame_err;
   logic                     overflow;
   logic                     parity_err;

   modport master (
      output rx, rd_en, clr,
      input  data, valid, count, busy, frame_err, overflow, parity_err
   );

   modport slave (
      input  rx, rd_en, clr,
      output data, valid, count, busy, frame_err, overflow, parity_err
   );
endinterface

// File: rtl/cereal_rx.sv
// cereal_rx: oversampling 8N1 receiver (idle high, LSB first) feeding a small
// show-ahead FIFO. Optional even-parity (8E1) framing is enabled by defining
// the macro CEREAL_RX_PARITY_EN; without it parity_err is held at 0.
module cereal_rx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DEPTH        = 4
) (
   input  logic       sysclk,
   input  logic       rst_n,
   cereal_rx_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   OCC_MAX = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   // Even parity bit for a data byte (bit that makes the total count of ones even).
   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   state_t          state_r;
   logic            rx_meta_r, rxs_r;
   logic [CW-1:0]   clk_cnt_r;
   logic [2:0]      bit_cnt_r;
   logic [7:0]      shift_r;
   logic            par_bad_r;
   logic            busy_r;
   logic            push_r;
   logic [7:0]      push_data_r;

   logic [7:0]      mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [AW:0]     count_r;
   logic [7:0]      data_r;
   logic            valid_r;
   logic            frame_err_r, overflow_r, parity_err_r;

   logic            pop_s, full_s, push_ok_s, ovf_set_s, ferr_set_s, perr_set_s;
   logic [AW-1:0]   rd_nx_s;
   logic [AW:0]     count_nx_s;
   logic [7:0]      head_nx_s;

   // Two-flop synchroniser for the asynchronous serial line; idles high.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_r <= 1'b1;
         rxs_r     <= 1'b1;
      end else begin
         rx_meta_r <= bus.rx;
         rxs_r     <= rx_meta_r;
      end
   end

   // Frame FSM: start validation, mid-bit sampling, stop/parity checks, break hold-off.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         clk_cnt_r   <= '0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'h00;
         par_bad_r   <= 1'b0;
         busy_r      <= 1'b0;
         push_r      <= 1'b0;
         push_data_r <= 8'h00;
      end else begin
         push_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               clk_cnt_r <= '0;
               bit_cnt_r <= 3'd0;
               par_bad_r <= 1'b0;
               if (!rxs_r) begin
                  state_r <= S_START;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            S_START: begin
               if (clk_cnt_r == HALF_M1) begin
                  clk_cnt_r <= '0;
                  if (!rxs_r) begin
                     state_r <= S_DATA;
                  end else begin
                     // Start bit vanished by mid-bit: treat as a glitch.
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            S_DATA: begin
               if (clk_cnt_r == FULL_M1) begin
                  clk_cnt_r <= '0;
                  shift_r   <= {rxs_r, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
                     bit_cnt_r <= 3'd0;
`ifdef CEREAL_RX_PARITY_EN
                     state_r   <= S_PARITY;
`else
                     state_r   <= S_STOP;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            S_PARITY: begin
               if (clk_cnt_r == FULL_M1) begin
                  clk_cnt_r <= '0;
                  state_r   <= S_STOP;
`ifdef CEREAL_RX_PARITY_EN
                  par_bad_r <= (rxs_r != even_par(shift_r));
`else
                  par_bad_r <= 1'b0;
`endif
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            S_STOP: begin
               if (clk_cnt_r == FULL_M1) begin
                  clk_cnt_r <= '0;
                  if (rxs_r) begin
                     state_r     <= S_IDLE;
                     busy_r      <= 1'b0;
                     push_r      <= !par_bad_r;
                     push_data_r <= shift_r;
                  end else begin
                     state_r     <= S_BREAK;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            S_BREAK: begin
               clk_cnt_r <= '0;
               if (rxs_r) begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= S_BREAK;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               clk_cnt_r <= '0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   // Flag set conditions and FIFO handshake qualification.
   always_comb begin
      ferr_set_s = (state_r == S_STOP) && (clk_cnt_r == FULL_M1) && !rxs_r;
`ifdef CEREAL_RX_PARITY_EN
      perr_set_s = (state_r == S_PARITY) && (clk_cnt_r == FULL_M1) &&
                   (rxs_r != even_par(shift_r));
`else
      perr_set_s = 1'b0;
`endif
      pop_s     = bus.rd_en && (count_r != '0);
      full_s    = (count_r == OCC_MAX);
      push_ok_s = push_r && (!full_s || pop_s);
      ovf_set_s = push_r && full_s && !pop_s;
   end

   // Next occupancy, read pointer and show-ahead head byte.
   always_comb begin
      if (pop_s) begin
         rd_nx_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_nx_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_nx_s = count_r + OCC_ONE;
         2'b01:   count_nx_s = count_r - OCC_ONE;
         default: count_nx_s = count_r;
      endcase
      if (count_nx_s == '0) begin
         head_nx_s = 8'h00;
      end else if (push_ok_s && (rd_nx_s == wr_ptr_r)) begin
         // Head is the slot being written this cycle.
         head_nx_s = push_data_r;
      end else begin
         head_nx_s = mem_r[rd_nx_s];
      end
   end

   // FIFO storage, pointers and registered consumer-facing outputs.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         data_r   <= 8'h00;
         valid_r  <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         rd_ptr_r <= rd_nx_s;
         count_r  <= count_nx_s;
         data_r   <= head_nx_s;
         valid_r  <= (count_nx_s != '0);
      end
   end

   // Sticky error flags; a set in the same cycle as clr keeps the flag high.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_r  <= 1'b0;
         overflow_r   <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         frame_err_r  <= ferr_set_s | (frame_err_r  & ~bus.clr);
         overflow_r   <= ovf_set_s  | (overflow_r   & ~bus.clr);
         parity_err_r <= perr_set_s | (parity_err_r & ~bus.clr);
      end
   end

   assign bus.data       = data_r;
   assign bus.valid      = valid_r;
   assign bus.count      = count_r;
   assign bus.busy       = busy_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.overflow   = overflow_r;
   assign bus.parity_err = parity_err_r;

endmodule
